// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Sequential shift-and-add multiplier computing Res = A * B + R, one
// multiplier bit per clock. It rebuilds a restoring divider's dividend from
// its quotient (A), divisor (B) and remainder (R), so it can run as the
// divider's reconstruction/check path behind that divider's output register.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request; sampled only in IDLE
//   A      multiplicand (quotient), WIDTH bits, captured on the accepting edge
//   B      multiplier (divisor), BWIDTH bits, captured on the accepting edge
//   R      addend (remainder), BWIDTH bits, captured on the accepting edge
//   busy   high while an operation is in RUN or DONE
//   done   one-cycle pulse; Res is valid from this cycle on
//   Res    product plus addend, WIDTH+BWIDTH bits, held until next completion
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
    parameter int WIDTH  = 8,
    parameter int BWIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH-1:0]         A,
    input  logic [BWIDTH-1:0]        B,
    input  logic [BWIDTH-1:0]        R,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH+BWIDTH-1:0]  Res
);

    localparam int RW = WIDTH + BWIDTH;
    localparam int CW = (BWIDTH > 1) ? $clog2(BWIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [RW-1:0]     acc;
    logic [RW-1:0]     a_sh;
    logic [BWIDTH-1:0] b_sh;
    logic [CW-1:0]     cnt;

    logic [RW-1:0]     acc_sum;
    logic              last_bit;

    // The accumulator never overflows: the largest result is
    // 2^RW - 2^WIDTH, so an RW-bit unsigned add is exact.
    assign acc_sum  = acc + (b_sh[0] ? a_sh : '0);
    assign last_bit = (cnt == CW'(BWIDTH - 1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    // NOTE: the default assignment before the case keeps this block purely
    // combinational; a missing branch would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Datapath. B=0 still runs all BWIDTH iterations; there is no early exit,
    // so latency is fixed regardless of operand values.
    // NOTE: every datapath register, including Res, is cleared by reset so an
    // aborted operation leaves no stale result visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            cnt  <= '0;
            Res  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= RW'(R);
                        a_sh <= RW'(A);
                        b_sh <= B;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    acc  <= acc_sum;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    // Publish the sum including this edge's partial product.
                    if (last_bit) Res <= acc_sum;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// Testbench for shift_add_multiplier (WIDTH=8, BWIDTH=4).
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on
// the rising edge.
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  A;
    logic [3:0]  B;
    logic [3:0]  R;
    logic        busy;
    logic        done;
    logic [11:0] Res;

    int n_cmp;
    int n_err;
    int cyc;

    shift_add_multiplier #(.WIDTH(8), .BWIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .Res   (Res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Runs one operation with a single-cycle start pulse. After the accepting
    // edge the operands are scrambled to show they were captured. Observation
    // starts at the first falling edge after the accepting edge (i=1) and is
    // bounded to 20 cycles; lat stays 0 if done never appears.
    task automatic do_op(input logic [7:0] a, input logic [3:0] b, input logic [3:0] r,
                         output logic [11:0] res_o, output int lat,
                         output int busy_cnt, output int done_cnt);
        @(negedge clk);
        start = 1'b1; A = a; B = b; R = r;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b; R = ~r;
        lat = 0; busy_cnt = 0; done_cnt = 0; res_o = 'x;
        for (int i = 1; i <= 20; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat == 0) begin
                    lat   = i;
                    res_o = Res;
                end
            end
            if (!busy) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (Res !== 12'd0) begin n_err++; $display("FAIL reset_res: got %0d expected 0", Res); end
        // Reset held across edges with start high must keep the block idle.
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_hold_busy: got %b expected 0", busy); end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_basic;
        logic [11:0] res; int lat, bc, dc;
        do_op(8'd10, 4'd3, 4'd1, res, lat, bc, dc);
        n_cmp++; if (res !== 12'd31) begin n_err++; $display("FAIL basic_res: got %0d expected 31", res); end
        n_cmp++; if (lat != 5)       begin n_err++; $display("FAIL basic_latency: got %0d expected 5", lat); end
        n_cmp++; if (bc != 5)        begin n_err++; $display("FAIL basic_busy_cycles: got %0d expected 5", bc); end
        n_cmp++; if (dc != 1)        begin n_err++; $display("FAIL basic_done_pulses: got %0d expected 1", dc); end
        // Res must hold after completion.
        repeat (3) @(negedge clk);
        n_cmp++; if (Res !== 12'd31) begin n_err++; $display("FAIL basic_res_hold: got %0d expected 31", Res); end
    endtask

    task automatic test_extremes;
        logic [11:0] res; int lat, bc, dc;
        do_op(8'd255, 4'd15, 4'd15, res, lat, bc, dc);
        n_cmp++; if (res !== 12'd3840) begin n_err++; $display("FAIL max_res: got %0d expected 3840", res); end
        n_cmp++; if (lat != 5)         begin n_err++; $display("FAIL max_latency: got %0d expected 5", lat); end
        do_op(8'd0, 4'd0, 4'd0, res, lat, bc, dc);
        n_cmp++; if (res !== 12'd0)    begin n_err++; $display("FAIL zero_res: got %0d expected 0", res); end
        n_cmp++; if (dc != 1)          begin n_err++; $display("FAIL zero_done_pulses: got %0d expected 1", dc); end
    endtask

    task automatic test_b_zero;
        logic [11:0] res; int lat, bc, dc;
        do_op(8'd200, 4'd0, 4'd7, res, lat, bc, dc);
        n_cmp++; if (res !== 12'd7) begin n_err++; $display("FAIL bzero_res: got %0d expected 7", res); end
        n_cmp++; if (lat != 5)      begin n_err++; $display("FAIL bzero_latency: got %0d expected 5", lat); end
        n_cmp++; if (bc != 5)       begin n_err++; $display("FAIL bzero_busy_cycles: got %0d expected 5", bc); end
    endtask

    task automatic test_start_ignored;
        logic [11:0] res; int lat, dc;
        @(negedge clk);
        start = 1'b1; A = 8'd12; B = 4'd5; R = 4'd0;
        @(posedge clk);
        lat = 0; dc = 0; res = 'x;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            // A second request two cycles after acceptance must be ignored.
            start = (i == 2);
            if (i == 2) begin A = 8'd1; B = 4'd1; R = 4'd0; end
            if (done) begin
                dc++;
                if (lat == 0) begin lat = i; res = Res; end
            end
        end
        start = 1'b0;
        n_cmp++; if (res !== 12'd60) begin n_err++; $display("FAIL ignored_res: got %0d expected 60", res); end
        n_cmp++; if (dc != 1)        begin n_err++; $display("FAIL ignored_done_pulses: got %0d expected 1", dc); end
        n_cmp++; if (lat != 5)       begin n_err++; $display("FAIL ignored_latency: got %0d expected 5", lat); end
        n_cmp++; if (Res !== 12'd60) begin n_err++; $display("FAIL ignored_res_hold: got %0d expected 60", Res); end
    endtask

    task automatic test_async_reset;
        logic [11:0] res; int lat, bc, dc;
        @(negedge clk);
        start = 1'b1; A = 8'd12; B = 4'd5; R = 4'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        // Mid-cycle, away from any clock edge.
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL arst_done: got %b expected 0", done); end
        n_cmp++; if (Res !== 12'd0) begin n_err++; $display("FAIL arst_res: got %0d expected 0", Res); end
        @(negedge clk);
        rst = 1'b0;
        dc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dc++;
        end
        n_cmp++; if (dc != 0) begin n_err++; $display("FAIL arst_no_done: got %0d pulses expected 0", dc); end
        do_op(8'd7, 4'd9, 4'd2, res, lat, bc, dc);
        n_cmp++; if (res !== 12'd65) begin n_err++; $display("FAIL arst_after_res: got %0d expected 65", res); end
    endtask

    // start held high; each completion immediately presents the next operand
    // set, taken from divider outputs (q = a_orig / b, r = a_orig % b).
    task automatic test_back_to_back;
        int prev_cyc;
        int idx_b, idx_a;
        bit got;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_before: got busy=%b expected 0", busy); end
        A = 8'd0; B = 4'd1; R = 4'd0;
        start = 1'b1;
        prev_cyc = -1;
        for (int idx = 0; idx < 15 * 256; idx++) begin
            idx_b = idx / 256 + 1;
            idx_a = idx % 256;
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (done) begin got = 1'b1; break; end
            end
            n_cmp++;
            if (!got) begin
                n_err++;
                $display("FAIL b2b_timeout: no done within 20 cycles for a_orig=%0d b=%0d", idx_a, idx_b);
                start = 1'b0;
                return;
            end
            n_cmp++;
            if (Res !== 12'(idx_a)) begin
                n_err++;
                $display("FAIL b2b_res: a_orig=%0d b=%0d got %0d expected %0d", idx_a, idx_b, Res, idx_a);
            end
            if (prev_cyc >= 0) begin
                n_cmp++;
                if (cyc - prev_cyc != 6) begin
                    n_err++;
                    $display("FAIL b2b_spacing: got %0d cycles expected 6", cyc - prev_cyc);
                end
            end
            prev_cyc = cyc;
            if (idx + 1 < 15 * 256) begin
                idx_b = (idx + 1) / 256 + 1;
                idx_a = (idx + 1) % 256;
                A = 8'(idx_a / idx_b);
                B = 4'(idx_b);
                R = 4'(idx_a % idx_b);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        R     = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_b_zero();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
